// File: rtl/ssd1306_pkg.sv
// SSD1306 command bytes, power-up init ROM, window helper and controller state types.
package ssd1306_pkg;

    localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;
    localparam logic [7:0] CMD_SEG_REMAP0   = 8'hA0;
    localparam logic [7:0] CMD_SEG_REMAP1   = 8'hA1;
    localparam logic [7:0] CMD_ENTIRE_RAM   = 8'hA4;
    localparam logic [7:0] CMD_ENTIRE_ON    = 8'hA5;
    localparam logic [7:0] CMD_NORMAL       = 8'hA6;
    localparam logic [7:0] CMD_INVERSE      = 8'hA7;
    localparam logic [7:0] CMD_COM_SCAN_INC = 8'hC0;
    localparam logic [7:0] CMD_COM_SCAN_DEC = 8'hC8;
    localparam logic [7:0] CMD_ADDR_MODE    = 8'h20;
    localparam logic [7:0] CMD_COL_ADDR     = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR    = 8'h22;

    typedef enum logic [1:0] {
        ADDR_HORZ = 2'b00,
        ADDR_VERT = 2'b01,
        ADDR_PAGE = 2'b10
    } addr_mode_t;

    localparam int unsigned INIT_LEN = 8;
    localparam int unsigned WIN_LEN  = 6;
    localparam int unsigned IDX_W    = 3;

    // Entry 0 is the rightmost element: AE,20,00,A1,C8,A6,A4,AF.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        CMD_DISPLAY_ON,
        CMD_ENTIRE_RAM,
        CMD_NORMAL,
        CMD_COM_SCAN_DEC,
        CMD_SEG_REMAP1,
        8'(ADDR_HORZ),
        CMD_ADDR_MODE,
        CMD_DISPLAY_OFF
    };

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_USER  = 3'd2,
        ST_WIN   = 3'd3,
        ST_FRAME = 3'd4
    } seq_state_t;

    typedef enum logic [2:0] {
        PH_LOAD = 3'd0,
        PH_RD   = 3'd1,
        PH_CAP  = 3'd2,
        PH_SEND = 3'd3,
        PH_WAIT = 3'd4
    } seq_phase_t;

    typedef enum logic [2:0] {
        B_IDLE   = 3'd0,
        B_LAUNCH = 3'd1,
        B_SETUP  = 3'd2,
        B_HI     = 3'd3,
        B_LO     = 3'd4,
        B_GAP    = 3'd5
    } tx_state_t;

    // Full-screen window: column range then page range.
    function automatic logic [7:0] win_cmd(input logic [IDX_W-1:0] idx,
                                           input logic [7:0] last_col,
                                           input logic [7:0] last_page);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_COL_ADDR;
            3'd1:    b = 8'h00;
            3'd2:    b = last_col;
            3'd3:    b = CMD_PAGE_ADDR;
            3'd4:    b = 8'h00;
            default: b = last_page;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ssd1306_spi4_tx.sv
// SPI mode-0 byte engine: one cs_n frame per byte, MSB first, dc held for the whole frame.
module ssd1306_spi4_tx
    import ssd1306_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_IDLE = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_dc,
    output logic       o_tx_ready_c,
    output logic       o_tx_done,
    output logic       o_spi_cs_n,
    output logic       o_spi_sck,
    output logic       o_spi_mosi,
    output logic       o_spi_dc
);

    localparam int unsigned CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_sh, w_sh_nxt;
    logic             r_cs_n, w_cs_n_nxt;
    logic             r_sck, w_sck_nxt;
    logic             r_mosi, w_mosi_nxt;
    logic             r_dc, w_dc_nxt;
    logic             r_done, w_done_nxt;
    logic             w_div_end;
    logic             w_gap_end;

    assign w_div_end    = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_gap_end    = (r_cnt == CNT_W'(CS_IDLE - 1));
    assign o_tx_ready_c = (r_state == B_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= B_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_cs_n  <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_dc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_sh    <= w_sh_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_dc    <= w_dc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Bit timing: launch dc/bit7, drop cs_n, then CLK_DIV-wide sck phases.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_sh_nxt    = r_sh;
        w_cs_n_nxt  = r_cs_n;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_dc_nxt    = r_dc;
        w_done_nxt  = 1'b0;
        case (r_state)
            B_IDLE: begin
                w_cnt_nxt = '0;
                if (i_tx_valid) begin
                    w_dc_nxt    = i_tx_dc;
                    w_mosi_nxt  = i_tx_data[7];
                    w_sh_nxt    = i_tx_data;
                    w_bit_nxt   = '0;
                    w_state_nxt = B_LAUNCH;
                end
            end
            B_LAUNCH: begin
                w_cs_n_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = B_SETUP;
            end
            B_SETUP: begin
                if (w_div_end) begin
                    w_sck_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = B_HI;
                end
            end
            B_HI: begin
                if (w_div_end) begin
                    w_sck_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_cs_n_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = B_GAP;
                    end else begin
                        w_mosi_nxt  = r_sh[6];
                        w_sh_nxt    = {r_sh[6:0], 1'b0};
                        w_bit_nxt   = r_bit + 3'd1;
                        w_state_nxt = B_LO;
                    end
                end
            end
            B_LO: begin
                if (w_div_end) begin
                    w_sck_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = B_HI;
                end
            end
            B_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = B_IDLE;
                end
            end
            default: begin
                w_state_nxt = B_IDLE;
            end
        endcase
    end

    assign o_tx_done  = r_done;
    assign o_spi_cs_n = r_cs_n;
    assign o_spi_sck  = r_sck;
    assign o_spi_mosi = r_mosi;
    assign o_spi_dc   = r_dc;

endmodule

// File: rtl/ssd1306_spi4_ctrl.sv
// SSD1306 4-wire SPI controller: init ROM playback, then frame refresh / user byte arbitration.
module ssd1306_spi4_ctrl
    import ssd1306_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_IDLE    = 2,
    parameter int unsigned DISP_W     = 128,
    parameter int unsigned DISP_PAGES = 8
) (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic       frame_start_i,
    output logic       frame_done_o,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       fb_rd_o,
    output logic [9:0] fb_addr_o,
    input  logic [7:0] fb_data_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_dc_i,
    output logic       spi_cs_no,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    output logic       spi_dc_o
);

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned FB_BYTES = DISP_W * DISP_PAGES;

    seq_state_t        r_state, w_state_nxt;
    seq_phase_t        r_phase, w_phase_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_fb_addr, w_fb_addr_nxt;
    logic              r_fb_rd, w_fb_rd_nxt;
    logic              r_pending, w_pending_nxt;
    logic              r_init_done, w_init_done_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              r_cmd_ready, w_cmd_ready_nxt;
    logic              r_busy, w_busy_nxt;
    logic [7:0]        r_tx_data, w_tx_data_nxt;
    logic              r_tx_dc, w_tx_dc_nxt;
    logic              w_tx_valid;
    logic              w_tx_ready_c;
    logic              w_tx_done;
    logic              w_byte_end;
    logic [7:0]        w_win_byte;

    assign w_tx_valid = (r_phase == PH_SEND);
    assign w_byte_end = (r_phase == PH_WAIT) && w_tx_done;
    assign w_win_byte = win_cmd(r_idx, 8'(DISP_W - 1), 8'(DISP_PAGES - 1));

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= ST_INIT;
            r_phase      <= PH_LOAD;
            r_idx        <= '0;
            r_addr       <= '0;
            r_fb_addr    <= '0;
            r_fb_rd      <= 1'b0;
            r_pending    <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_tx_data    <= '0;
            r_tx_dc      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_idx        <= w_idx_nxt;
            r_addr       <= w_addr_nxt;
            r_fb_addr    <= w_fb_addr_nxt;
            r_fb_rd      <= w_fb_rd_nxt;
            r_pending    <= w_pending_nxt;
            r_init_done  <= w_init_done_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_dc      <= w_tx_dc_nxt;
        end
    end

    // Sequencer: each byte goes LOAD -> (RD -> CAP for framebuffer) -> SEND -> WAIT.
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_idx_nxt        = r_idx;
        w_addr_nxt       = r_addr;
        w_fb_addr_nxt    = r_fb_addr;
        w_fb_rd_nxt      = 1'b0;
        w_pending_nxt    = r_pending | frame_start_i;
        w_init_done_nxt  = r_init_done;
        w_frame_done_nxt = 1'b0;
        w_cmd_ready_nxt  = 1'b0;
        w_tx_data_nxt    = r_tx_data;
        w_tx_dc_nxt      = r_tx_dc;

        if (r_phase == PH_SEND && w_tx_ready_c) begin
            w_phase_nxt = PH_WAIT;
        end

        case (r_state)
            ST_INIT: begin
                if (r_phase == PH_LOAD) begin
                    w_tx_data_nxt = INIT_ROM[r_idx];
                    w_tx_dc_nxt   = 1'b0;
                    w_phase_nxt   = PH_SEND;
                end
                if (w_byte_end) begin
                    w_phase_nxt = PH_LOAD;
                    if (r_idx == IDX_W'(INIT_LEN - 1)) begin
                        w_init_done_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                w_pending_nxt = r_pending;
                w_phase_nxt   = PH_LOAD;
                if (r_pending || frame_start_i) begin
                    w_pending_nxt = 1'b0;
                    w_idx_nxt     = '0;
                    w_state_nxt   = ST_WIN;
                end else if (cmd_valid_i) begin
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = ST_USER;
                end
            end
            ST_USER: begin
                if (r_phase == PH_LOAD) begin
                    w_tx_data_nxt = cmd_data_i;
                    w_tx_dc_nxt   = cmd_dc_i;
                    w_phase_nxt   = PH_SEND;
                end
                if (w_byte_end) begin
                    w_phase_nxt = PH_LOAD;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WIN: begin
                if (r_phase == PH_LOAD) begin
                    w_tx_data_nxt = w_win_byte;
                    w_tx_dc_nxt   = 1'b0;
                    w_phase_nxt   = PH_SEND;
                end
                if (w_byte_end) begin
                    w_phase_nxt = PH_LOAD;
                    if (r_idx == IDX_W'(WIN_LEN - 1)) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = ST_FRAME;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_FRAME: begin
                // RAM answers one clock after the strobe, so capture in PH_CAP.
                case (r_phase)
                    PH_LOAD: begin
                        w_fb_rd_nxt   = 1'b1;
                        w_fb_addr_nxt = r_addr;
                        w_phase_nxt   = PH_RD;
                    end
                    PH_RD: begin
                        w_phase_nxt = PH_CAP;
                    end
                    PH_CAP: begin
                        w_tx_data_nxt = fb_data_i;
                        w_tx_dc_nxt   = 1'b1;
                        w_phase_nxt   = PH_SEND;
                    end
                    default: begin
                    end
                endcase
                if (w_byte_end) begin
                    w_phase_nxt = PH_LOAD;
                    if (r_addr == ADDR_W'(FB_BYTES - 1)) begin
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_phase_nxt = PH_LOAD;
                w_idx_nxt   = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    ssd1306_spi4_tx #(
        .CLK_DIV (CLK_DIV),
        .CS_IDLE (CS_IDLE)
    ) u_tx (
        .i_clk        (clk_i),
        .i_rst_n      (rst_in),
        .i_tx_valid   (w_tx_valid),
        .i_tx_data    (r_tx_data),
        .i_tx_dc      (r_tx_dc),
        .o_tx_ready_c (w_tx_ready_c),
        .o_tx_done    (w_tx_done),
        .o_spi_cs_n   (spi_cs_no),
        .o_spi_sck    (spi_sck_o),
        .o_spi_mosi   (spi_mosi_o),
        .o_spi_dc     (spi_dc_o)
    );

    assign frame_done_o = r_frame_done;
    assign init_done_o  = r_init_done;
    assign busy_o       = r_busy;
    assign fb_rd_o      = r_fb_rd;
    assign fb_addr_o    = r_fb_addr;
    assign cmd_ready_o  = r_cmd_ready;

endmodule

// File: tb/tb_ssd1306_spi4_ctrl.sv
// Directed bench for ssd1306_spi4_ctrl with a small SSD1306 SPI receiver model and framebuffer RAM.
module tb_ssd1306_spi4_ctrl;

    logic       clk_i;
    logic       rst_in;
    logic       frame_start_i;
    logic       frame_done_o;
    logic       init_done_o;
    logic       busy_o;
    logic       fb_rd_o;
    logic [9:0] fb_addr_o;
    logic [7:0] fb_data_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_data_i;
    logic       cmd_dc_i;
    logic       spi_cs_no;
    logic       spi_sck_o;
    logic       spi_mosi_o;
    logic       spi_dc_o;

    int checks   = 0;
    int failures = 0;

    ssd1306_spi4_ctrl #(
        .CLK_DIV    (1),
        .CS_IDLE    (1),
        .DISP_W     (128),
        .DISP_PAGES (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_in        (rst_in),
        .frame_start_i (frame_start_i),
        .frame_done_o  (frame_done_o),
        .init_done_o   (init_done_o),
        .busy_o        (busy_o),
        .fb_rd_o       (fb_rd_o),
        .fb_addr_o     (fb_addr_o),
        .fb_data_i     (fb_data_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_data_i    (cmd_data_i),
        .cmd_dc_i      (cmd_dc_i),
        .spi_cs_no     (spi_cs_no),
        .spi_sck_o     (spi_sck_o),
        .spi_mosi_o    (spi_mosi_o),
        .spi_dc_o      (spi_dc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Framebuffer RAM holding byte i at address i.
    always @(posedge clk_i) begin
        if (fb_rd_o) fb_data_i <= fb_addr_o[7:0];
    end

    int fd_cnt  = 0;
    int rdy_cnt = 0;
    always @(negedge clk_i) begin
        if (frame_done_o) fd_cnt++;
        if (cmd_ready_o) rdy_cnt++;
    end

    // Display model: receive bytes on cs_n rise, track addressing and inverse state.
    logic [8:0] rx_q[$];
    logic [7:0] m_sh      = 8'h00;
    int         m_bits    = 0;
    logic       p_cs      = 1'b1;
    logic       p_sck     = 1'b0;
    logic       p_mosi    = 1'b0;
    logic       p_dc      = 1'b0;
    int         mosi_viol = 0;
    int         dc_viol   = 0;
    int         bit_viol  = 0;
    logic [1:0] m_mode    = 2'b10;
    logic       m_inverse = 1'b0;
    int         m_kind    = 0;
    int         m_argn    = 0;
    int         m_col = 0, m_page = 0, m_cs = 0, m_ce = 127, m_ps = 0, m_pe = 7;
    logic       m_first   = 1'b0;
    int         first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    logic [7:0] first_d = 8'h00, last_d = 8'h00;

    task automatic model_byte(input logic [7:0] b, input logic d);
        if (d) begin
            if (m_first) begin
                first_x = m_col; first_y = m_page; first_d = b; m_first = 1'b0;
            end
            last_x = m_col; last_y = m_page; last_d = b;
            if (m_col >= m_ce) begin
                m_col  = m_cs;
                m_page = (m_page >= m_pe) ? m_ps : m_page + 1;
            end else begin
                m_col++;
            end
        end else if (m_kind != 0) begin
            if (m_kind == 1) begin
                m_mode = b[1:0];
                m_kind = 0;
            end else if (m_kind == 2) begin
                if (m_argn == 0) begin m_cs = int'(b); m_col = int'(b); m_argn = 1; end
                else begin m_ce = int'(b); m_kind = 0; end
            end else begin
                if (m_argn == 0) begin m_ps = int'(b); m_page = int'(b); m_argn = 1; end
                else begin m_pe = int'(b); m_kind = 0; m_first = 1'b1; end
            end
        end else begin
            case (b)
                8'h20: begin m_kind = 1; m_argn = 0; end
                8'h21: begin m_kind = 2; m_argn = 0; end
                8'h22: begin m_kind = 3; m_argn = 0; end
                8'hA6: m_inverse = 1'b0;
                8'hA7: m_inverse = 1'b1;
                default: ;
            endcase
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_in) begin
            m_bits = 0; p_cs = 1'b1; p_sck = 1'b0; p_mosi = 1'b0; p_dc = 1'b0;
        end else begin
            if (!spi_cs_no && !p_cs && spi_dc_o !== p_dc) dc_viol++;
            if (!spi_cs_no && spi_sck_o && p_sck && spi_mosi_o !== p_mosi) mosi_viol++;
            if (!spi_cs_no && p_cs) m_bits = 0;
            if (!spi_cs_no && spi_sck_o && !p_sck) begin
                m_sh = {m_sh[6:0], spi_mosi_o};
                m_bits++;
            end
            if (spi_cs_no && !p_cs) begin
                if (m_bits != 8) bit_viol++;
                rx_q.push_back({p_dc, m_sh});
                model_byte(m_sh, p_dc);
            end
            p_cs = spi_cs_no; p_sck = spi_sck_o; p_mosi = spi_mosi_o; p_dc = spi_dc_o;
        end
    end

    task automatic test_reset();
        rst_in = 1'b0; frame_start_i = 1'b0; cmd_valid_i = 1'b0;
        cmd_data_i = 8'h00; cmd_dc_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (spi_cs_no !== 1'b1) begin
            failures++; $display("FAIL reset_cs_n got=%b exp=1", spi_cs_no);
        end
        checks++;
        if ({spi_sck_o, spi_mosi_o, spi_dc_o} !== 3'b000) begin
            failures++; $display("FAIL reset_spi_pins got=%b exp=000", {spi_sck_o, spi_mosi_o, spi_dc_o});
        end
        checks++;
        if ({busy_o, init_done_o, cmd_ready_o, fb_rd_o, frame_done_o} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_status got=%b exp=00000", {busy_o, init_done_o, cmd_ready_o, fb_rd_o, frame_done_o});
        end
        checks++;
        if (fb_addr_o !== 10'd0) begin
            failures++; $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr_o);
        end
    endtask

    task automatic check_init_seq(input int base, input string tag);
        logic [7:0] rom [8];
        rom = '{8'hAE, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hA6, 8'hA4, 8'hAF};
        checks++;
        if (rx_q.size() - base !== 8) begin
            failures++; $display("FAIL %s_count got=%0d exp=8", tag, rx_q.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rx_q[base + i] !== {1'b0, rom[i]}) begin
                    failures++; $display("FAIL %s_byte%0d got=%h exp=%h", tag, i, rx_q[base + i], {1'b0, rom[i]});
                end
            end
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done_o && n < 3000) begin @(negedge clk_i); n++; end
        checks++;
        if (init_done_o !== 1'b1) begin
            failures++; $display("FAIL %s_init_done got=%b exp=1 (timeout)", tag, init_done_o);
        end
    endtask

    task automatic test_init();
        int base;
        base = rx_q.size();
        @(negedge clk_i);
        rst_in = 1'b1;
        wait_init("init");
        check_init_seq(base, "init");
        checks++;
        if (m_mode !== 2'b00) begin
            failures++; $display("FAIL init_addr_mode got=%0d exp=0", m_mode);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++; $display("FAIL init_busy_idle got=%b exp=0", busy_o);
        end
    endtask

    task automatic test_user_cmd();
        int base, rdy0, n;
        logic seen;
        base = rx_q.size(); rdy0 = rdy_cnt; seen = 1'b0;
        cmd_valid_i = 1'b1; cmd_data_i = 8'hA7; cmd_dc_i = 1'b0;
        for (n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            if (cmd_ready_o) seen = 1'b1;
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        n = 0;
        while (busy_o && n < 200) begin @(negedge clk_i); n++; end
        repeat (3) @(negedge clk_i);
        checks++;
        if (!seen || rdy_cnt - rdy0 != 1) begin
            failures++; $display("FAIL user_ready_pulse seen=%b cycles=%0d exp=1", seen, rdy_cnt - rdy0);
        end
        checks++;
        if (rx_q.size() - base != 1 || rx_q[base] !== 9'h0A7) begin
            failures++; $display("FAIL user_byte count=%0d got=%h exp=0a7", rx_q.size() - base, rx_q[rx_q.size() - 1]);
        end
        checks++;
        if (m_inverse !== 1'b1) begin
            failures++; $display("FAIL user_inverse got=%b exp=1", m_inverse);
        end
    endtask

    task automatic test_frame_arbitration();
        int base, fd0, rdy0, n, bad, bad_idx, fd_at_ack;
        logic seen;
        logic [7:0] win [6];
        win = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        base = rx_q.size(); fd0 = fd_cnt; rdy0 = rdy_cnt; seen = 1'b0; fd_at_ack = -1;
        frame_start_i = 1'b1; cmd_valid_i = 1'b1; cmd_data_i = 8'hA6; cmd_dc_i = 1'b0;
        @(negedge clk_i);
        frame_start_i = 1'b0;
        n = 0;
        while (!fb_rd_o && n < 500) begin @(negedge clk_i); n++; end
        repeat (10) @(negedge clk_i);
        frame_start_i = 1'b1; @(negedge clk_i); frame_start_i = 1'b0;
        repeat (30) @(negedge clk_i);
        frame_start_i = 1'b1; @(negedge clk_i); frame_start_i = 1'b0;
        for (n = 0; n < 60000 && !seen; n++) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin seen = 1'b1; fd_at_ack = fd_cnt - fd0; end
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        n = 0;
        while (busy_o && n < 200) begin @(negedge clk_i); n++; end
        repeat (200) @(negedge clk_i);

        checks++;
        if (!seen || fd_at_ack != 2) begin
            failures++; $display("FAIL arb_cmd_after_frames seen=%b frames_before_ack=%0d exp=2", seen, fd_at_ack);
        end
        checks++;
        if (fd_cnt - fd0 != 2 || rdy_cnt - rdy0 != 1) begin
            failures++; $display("FAIL arb_pulse_counts frame_done=%0d ready=%0d exp=2,1", fd_cnt - fd0, rdy_cnt - rdy0);
        end
        checks++;
        if (rx_q.size() - base != 2 * 1030 + 1) begin
            failures++; $display("FAIL arb_byte_count got=%0d exp=%0d", rx_q.size() - base, 2 * 1030 + 1);
        end else begin
            bad = 0; bad_idx = -1;
            for (int f = 0; f < 2; f++) begin
                for (int i = 0; i < 6; i++)
                    if (rx_q[base + f * 1030 + i] !== {1'b0, win[i]}) begin bad++; if (bad_idx < 0) bad_idx = f * 1030 + i; end
                for (int i = 0; i < 1024; i++)
                    if (rx_q[base + f * 1030 + 6 + i] !== {1'b1, 8'(i)}) begin bad++; if (bad_idx < 0) bad_idx = f * 1030 + 6 + i; end
            end
            checks++;
            if (bad != 0) begin
                failures++; $display("FAIL frame_contents bad=%0d first_at=%0d got=%h", bad, bad_idx, rx_q[base + bad_idx]);
            end
            checks++;
            if (rx_q[base + 2060] !== 9'h0A6) begin
                failures++; $display("FAIL arb_cmd_byte got=%h exp=0a6", rx_q[base + 2060]);
            end
        end
        checks++;
        if (first_x != 0 || first_y != 0 || first_d !== 8'h00) begin
            failures++; $display("FAIL frame_first_pixel got=(%0d,%0d)=%h exp=(0,0)=00", first_x, first_y, first_d);
        end
        checks++;
        if (last_x != 127 || last_y != 7 || last_d !== 8'hFF) begin
            failures++; $display("FAIL frame_last_pixel got=(%0d,%0d)=%h exp=(127,7)=ff", last_x, last_y, last_d);
        end
        checks++;
        if (fb_addr_o !== 10'd1023 || busy_o !== 1'b0) begin
            failures++; $display("FAIL frame_idle_after got addr=%0d busy=%b exp 1023,0", fb_addr_o, busy_o);
        end
        checks++;
        if (m_inverse !== 1'b0) begin
            failures++; $display("FAIL arb_inverse got=%b exp=0", m_inverse);
        end
        checks++;
        if (mosi_viol != 0 || dc_viol != 0 || bit_viol != 0) begin
            failures++; $display("FAIL spi_framing mosi=%0d dc=%0d bits=%0d exp=0,0,0", mosi_viol, dc_viol, bit_viol);
        end
    endtask

    task automatic test_reset_mid_byte();
        int n, rises, base;
        logic prev;
        frame_start_i = 1'b1; @(negedge clk_i); frame_start_i = 1'b0;
        n = 0;
        while (!(spi_dc_o && !spi_cs_no) && n < 1000) begin @(negedge clk_i); n++; end
        rises = 0; prev = spi_sck_o;
        for (n = 0; n < 100 && rises < 3; n++) begin
            if (spi_sck_o && !prev) rises++;
            prev = spi_sck_o;
            if (rises < 3) @(negedge clk_i);
        end
        checks++;
        if (rises != 3 || spi_cs_no !== 1'b0) begin
            failures++; $display("FAIL midbyte_setup rises=%0d cs_n=%b exp=3,0", rises, spi_cs_no);
        end
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if (spi_cs_no !== 1'b1 || spi_sck_o !== 1'b0) begin
            failures++; $display("FAIL midbyte_abort cs_n=%b sck=%b exp=1,0", spi_cs_no, spi_sck_o);
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if (init_done_o !== 1'b0) begin
            failures++; $display("FAIL midbyte_init_cleared got=%b exp=0", init_done_o);
        end
        base = rx_q.size();
        rst_in = 1'b1;
        wait_init("replay");
        check_init_seq(base, "replay");
    endtask

    initial begin
        test_reset();
        test_init();
        test_user_cmd();
        test_frame_arbitration();
        test_reset_mid_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
